// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-access stage: RV32I load/store opcodes,
// funct3 widths, FSM states and the alignment rule for each access width.
package mem_access_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // Unsupported funct3 values are reported as misaligned so they never reach the bus.
  function automatic logic is_misaligned(input logic is_load, input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (funct3)
      F3_B:    mis = 1'b0;
      F3_H:    mis = addr_lo[0];
      F3_W:    mis = |addr_lo;
      F3_BU:   mis = !is_load;
      F3_HU:   mis = !is_load || addr_lo[0];
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_lsu_align.sv
// Byte-lane steering: store strobes/replicated write data and load lane
// selection with sign or zero extension. Purely combinational.
module lsu_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_v,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    wstrb = 4'b0000;
    wdata = store_v;
    case (funct3)
      F3_B: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_v[7:0]}};
      end
      F3_H: begin
        wstrb = 4'b0011 << addr_lo;
        wdata = {2{store_v[15:0]}};
      end
      F3_W:    wstrb = 4'b1111;
      default: wstrb = 4'b0000;
    endcase
  end

  always_comb begin
    lane_byte = rdata[7:0];
    case (addr_lo)
      2'd1:    lane_byte = rdata[15:8];
      2'd2:    lane_byte = rdata[23:16];
      2'd3:    lane_byte = rdata[31:24];
      default: lane_byte = rdata[7:0];
    endcase
    lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
      F3_W:    load_data = rdata;
      F3_BU:   load_data = {24'b0, lane_byte};
      F3_HU:   load_data = {16'b0, lane_half};
      default: load_data = 32'b0;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Pipeline memory-access stage: latches the execute result, runs one data
// memory transaction per aligned load/store and presents the writeback value.
module mem_access
  import mem_access_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic        E_VALID,
  input  logic [6:0]  E_OPCODE,
  input  logic [2:0]  E_FUNCT3,
  input  logic [4:0]  E_REG_D,
  input  logic [31:0] E_RESULT,
  input  logic [31:0] E_STORE_V,
  output logic        DMEM_RDEN,
  output logic        DMEM_WREN,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  output logic [3:0]  DMEM_WSTRB,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_READY,
  output logic        M_VALID,
  output logic [4:0]  M_REG_D,
  output logic [31:0] M_REG_D_V,
  output logic        M_STALL_REQ,
  output logic        M_ERR
);

  logic        lat_valid;
  logic [6:0]  lat_opcode;
  logic [2:0]  lat_funct3;
  logic [4:0]  lat_rd;
  logic [31:0] lat_result;
  logic [31:0] lat_store_v;
  logic [31:0] rdata_q;

  mem_state_t state, state_next;

  logic        is_load, is_store, is_mem, misaligned, mem_ok;
  logic [3:0]  wstrb;
  logic [31:0] load_data;

  always_ff @(posedge CLK) begin
    if (RST) begin
      lat_valid   <= 1'b0;
      lat_opcode  <= '0;
      lat_funct3  <= '0;
      lat_rd      <= '0;
      lat_result  <= '0;
      lat_store_v <= '0;
    end else if (!STALL) begin
      if (FLUSH) begin
        lat_valid  <= 1'b0;
        lat_opcode <= '0;
        lat_result <= '0;
      end else begin
        lat_valid   <= E_VALID;
        lat_opcode  <= E_OPCODE;
        lat_funct3  <= E_FUNCT3;
        lat_rd      <= E_REG_D;
        lat_result  <= E_RESULT;
        lat_store_v <= E_STORE_V;
      end
    end
  end

  assign is_load    = (lat_opcode == OP_LOAD);
  assign is_store   = (lat_opcode == OP_STORE);
  assign is_mem     = is_load || is_store;
  assign misaligned = is_misaligned(is_load, lat_funct3, lat_result[1:0]);
  assign mem_ok     = lat_valid && is_mem && !misaligned;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Read data is captured once so DONE outputs stay put however long the pipe stalls.
  always_ff @(posedge CLK) begin
    if (RST)                              rdata_q <= '0;
    else if (state == BUSY && DMEM_READY) rdata_q <= DMEM_RDATA;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_ok) state_next = BUSY;
      BUSY:    if (DMEM_READY) state_next = DONE;
      DONE:    if (!STALL) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  lsu_align u_align (
    .funct3    (lat_funct3),
    .addr_lo   (lat_result[1:0]),
    .store_v   (lat_store_v),
    .rdata     (rdata_q),
    .wstrb     (wstrb),
    .wdata     (DMEM_WDATA),
    .load_data (load_data)
  );

  always_comb begin
    DMEM_RDEN   = 1'b0;
    DMEM_WREN   = 1'b0;
    M_VALID     = 1'b0;
    M_REG_D     = '0;
    M_REG_D_V   = '0;
    M_STALL_REQ = 1'b0;
    M_ERR       = 1'b0;
    if (lat_valid) begin
      if (!is_mem) begin
        M_VALID   = 1'b1;
        M_REG_D   = lat_rd;
        M_REG_D_V = lat_result;
      end else if (misaligned) begin
        M_VALID = 1'b1;
        M_ERR   = 1'b1;
      end else begin
        M_STALL_REQ = (state != DONE);
        DMEM_RDEN   = (state == IDLE) && is_load;
        DMEM_WREN   = (state == IDLE) && is_store;
        if (state == DONE) begin
          M_VALID = 1'b1;
          if (is_load) begin
            M_REG_D   = lat_rd;
            M_REG_D_V = load_data;
          end
        end
      end
    end
  end

  assign DMEM_ADDR  = {lat_result[31:2], 2'b00};
  assign DMEM_WSTRB = DMEM_WREN ? wstrb : 4'b0000;

endmodule
